// File: rtl/can_tx_bitstuff_if.sv
// Bit-serial handshake between the MAC FSM (master) and the CAN transmit bit engine (slave).
interface can_tx_bitstuff_if;
    logic tx_valid;
    logic tx_bit;
    logic tx_ack;

    modport master (output tx_valid, output tx_bit, input tx_ack);
    modport slave  (input tx_valid, input tx_bit, output tx_ack);
endinterface

// File: rtl/can_tx_bitstuff.sv
// CAN transmit bit engine: drives tx at each sendpoint, inserts stuff bits, monitors the bus.
// Define CAN_TX_BITMON_EN to build the smplpoint bit-error / arbitration-loss monitor.
module can_tx_bitstuff #(
    parameter int STUFF_LIMIT = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     prescale_en,
    input  logic                     sendpoint,
    input  logic                     smplpoint,
    input  logic                     smpldbit,
    input  logic                     stuff_en,
    input  logic                     arb_field,
    input  logic                     abort,
    can_tx_bitstuff_if.slave         mac_if,
    output logic                     tx,
    output logic                     stuff_active,
    output logic                     bit_err,
    output logic                     arb_lost,
    output logic [1:0]               txst
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        STUFF = 2'd2
    } tx_state_t;

    localparam logic [2:0] LIMIT = 3'(STUFF_LIMIT);

    tx_state_t  state;
    logic [2:0] run_cnt;
    logic       last_bit;
    logic       tx_ack_q;

    assign mac_if.tx_ack = tx_ack_q;
    assign txst          = state;

`ifndef CAN_TX_BITMON_EN
    logic unused_mon;
    assign unused_mon = ^{smplpoint, smpldbit, arb_field};
    assign bit_err    = 1'b0;
    assign arb_lost   = 1'b0;
`endif

    // sendpoint work beats monitoring; a stuff bit leaves the MAC's pending bit un-acked
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            tx           <= 1'b1;
            run_cnt      <= 3'd0;
            last_bit     <= 1'b1;
            stuff_active <= 1'b0;
            tx_ack_q     <= 1'b0;
`ifdef CAN_TX_BITMON_EN
            bit_err      <= 1'b0;
            arb_lost     <= 1'b0;
`endif
        end else if (prescale_en) begin
            tx_ack_q <= 1'b0;
`ifdef CAN_TX_BITMON_EN
            bit_err  <= 1'b0;
            arb_lost <= 1'b0;
`endif
            if (abort) begin
                state        <= IDLE;
                tx           <= 1'b1;
                run_cnt      <= 3'd0;
                stuff_active <= 1'b0;
            end else if (sendpoint) begin
                if (stuff_en && (run_cnt == LIMIT)) begin
                    state        <= STUFF;
                    tx           <= ~last_bit;
                    last_bit     <= ~last_bit;
                    run_cnt      <= 3'd1;
                    stuff_active <= 1'b1;
                end else if (mac_if.tx_valid) begin
                    state        <= DRIVE;
                    tx           <= mac_if.tx_bit;
                    tx_ack_q     <= 1'b1;
                    stuff_active <= 1'b0;
                    if (stuff_en) begin
                        if (mac_if.tx_bit == last_bit) begin
                            run_cnt <= (run_cnt == LIMIT) ? run_cnt : run_cnt + 3'd1;
                        end else begin
                            run_cnt <= 3'd1;
                        end
                        last_bit <= mac_if.tx_bit;
                    end
                end else begin
                    state        <= IDLE;
                    tx           <= 1'b1;
                    stuff_active <= 1'b0;
                end
            end
`ifdef CAN_TX_BITMON_EN
            else if (smplpoint && (state != IDLE) && (smpldbit != tx)) begin
                if (tx && arb_field && (state == DRIVE)) begin
                    arb_lost     <= 1'b1;
                    state        <= IDLE;
                    tx           <= 1'b1;
                    stuff_active <= 1'b0;
                end else begin
                    bit_err <= 1'b1;
                end
            end
`endif
            if (!stuff_en) begin
                run_cnt  <= 3'd0;
                last_bit <= 1'b1;
            end
        end
    end

endmodule
